// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores over a req/gnt/rvalid data port,
// formats load data and registers the MEM/WB payload for write-back.
module mem_stage #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ex_valid_i,
  input  logic [DATA_WIDTH-1:0]     alu_result_i,
  input  logic [DATA_WIDTH-1:0]     rs2_data_i,
  input  logic [DATA_WIDTH-1:0]     pc_plus4_i,
  input  logic [DATA_WIDTH-1:0]     instruction_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
  input  logic                      RegWrite_i,
  input  logic                      MemRead_i,
  input  logic                      MemWrite_i,
  input  logic [2:0]                funct3_i,
  input  logic [1:0]                WBSel_i,
  output logic                      dmem_req_o,
  output logic                      dmem_we_o,
  output logic [ADDR_WIDTH-1:0]     dmem_addr_o,
  output logic [3:0]                dmem_be_o,
  output logic [DATA_WIDTH-1:0]     dmem_wdata_o,
  input  logic                      dmem_gnt_i,
  input  logic                      dmem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]     dmem_rdata_i,
  output logic                      mem_stall_o,
  output logic                      wb_valid_o,
  output logic [DATA_WIDTH-1:0]     alu_result_o,
  output logic [DATA_WIDTH-1:0]     rd_data_o,
  output logic [DATA_WIDTH-1:0]     pc_plus4_o,
  output logic [DATA_WIDTH-1:0]     instruction_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
  output logic                      RegWrite_o,
  output logic [1:0]                WBSel_o,
  output logic                      misaligned_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic                  is_mem;
  logic                  misaligned;
  logic                  memop;
  logic                  complete;
  logic [1:0]            byte_off;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] load_data;

  assign byte_off = alu_result_i[1:0];
  assign is_mem   = ex_valid_i & (MemRead_i | MemWrite_i);

  always_comb begin
    misaligned = 1'b0;
    case (funct3_i[1:0])
      2'b01:   misaligned = byte_off[0];
      2'b10:   misaligned = (byte_off != 2'b00);
      default: misaligned = 1'b0;
    endcase
    misaligned = misaligned & is_mem;
  end

  assign memop = is_mem & ~misaligned;

  // A request that was granted but whose data has not returned is tracked in
  // WAIT_RD; stores finish on their grant and never leave IDLE/REQ.
  always_comb begin
    state_d    = state_q;
    dmem_req_o = 1'b0;
    complete   = 1'b0;
    case (state_q)
      IDLE, REQ: begin
        if (memop) begin
          dmem_req_o = 1'b1;
          if (dmem_gnt_i) begin
            if (MemWrite_i) begin
              complete = 1'b1;
              state_d  = IDLE;
            end else begin
              state_d  = WAIT_RD;
            end
          end else begin
            state_d = REQ;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_RD: begin
        if (dmem_rvalid_i) begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_stall_o = memop & ~complete;
  assign dmem_we_o   = memop & MemWrite_i;
  assign dmem_addr_o = {alu_result_i[ADDR_WIDTH-1:2], 2'b00};

  always_comb begin
    dmem_be_o    = 4'hF;
    dmem_wdata_o = rs2_data_i;
    if (MemWrite_i) begin
      case (funct3_i[1:0])
        2'b00: begin
          dmem_be_o    = 4'b0001 << byte_off;
          dmem_wdata_o = {4{rs2_data_i[7:0]}};
        end
        2'b01: begin
          dmem_be_o    = 4'b0011 << {byte_off[1], 1'b0};
          dmem_wdata_o = {2{rs2_data_i[15:0]}};
        end
        default: begin
          dmem_be_o    = 4'hF;
          dmem_wdata_o = rs2_data_i;
        end
      endcase
    end
  end

  always_comb begin
    ld_byte = dmem_rdata_i[7:0];
    case (byte_off)
      2'd0:    ld_byte = dmem_rdata_i[7:0];
      2'd1:    ld_byte = dmem_rdata_i[15:8];
      2'd2:    ld_byte = dmem_rdata_i[23:16];
      default: ld_byte = dmem_rdata_i[31:24];
    endcase
    ld_half = byte_off[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (funct3_i)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  load_data = {24'd0, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  load_data = {16'd0, ld_half};
      default: load_data = dmem_rdata_i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Payload is only refreshed when a slot is actually handed to WB; bubbles
  // clear the control bits and leave the data fields as they were.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid_o    <= 1'b0;
      alu_result_o  <= '0;
      rd_data_o     <= '0;
      pc_plus4_o    <= '0;
      instruction_o <= '0;
      rd_addr_o     <= '0;
      RegWrite_o    <= 1'b0;
      WBSel_o       <= '0;
      misaligned_o  <= 1'b0;
    end else if (complete | (ex_valid_i & ~memop)) begin
      wb_valid_o    <= 1'b1;
      alu_result_o  <= alu_result_i;
      rd_data_o     <= (complete & ~MemWrite_i) ? load_data : '0;
      pc_plus4_o    <= pc_plus4_i;
      instruction_o <= instruction_i;
      rd_addr_o     <= rd_addr_i;
      RegWrite_o    <= RegWrite_i & ~misaligned;
      WBSel_o       <= WBSel_i;
      misaligned_o  <= misaligned;
    end else begin
      wb_valid_o    <= 1'b0;
      RegWrite_o    <= 1'b0;
      misaligned_o  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed plus randomized bench for mem_stage; expectations come from an
// arithmetic model of load/store formatting and handshake timing.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [31:0] alu_result, rs2_data, pc_plus4, instruction;
  logic [4:0]  rd_addr;
  logic        reg_write, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [1:0]  wb_sel;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        mem_stall, wb_valid;
  logic [31:0] alu_result_q, rd_data_q, pc_plus4_q, instruction_q;
  logic [4:0]  rd_addr_q;
  logic        reg_write_q;
  logic [1:0]  wb_sel_q;
  logic        misaligned_q;

  int checks   = 0;
  int failures = 0;

  mem_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid_i(ex_valid),
    .alu_result_i(alu_result), .rs2_data_i(rs2_data), .pc_plus4_i(pc_plus4),
    .instruction_i(instruction), .rd_addr_i(rd_addr), .RegWrite_i(reg_write),
    .MemRead_i(mem_read), .MemWrite_i(mem_write), .funct3_i(funct3),
    .WBSel_i(wb_sel), .dmem_req_o(dmem_req), .dmem_we_o(dmem_we),
    .dmem_addr_o(dmem_addr), .dmem_be_o(dmem_be), .dmem_wdata_o(dmem_wdata),
    .dmem_gnt_i(dmem_gnt), .dmem_rvalid_i(dmem_rvalid), .dmem_rdata_i(dmem_rdata),
    .mem_stall_o(mem_stall), .wb_valid_o(wb_valid), .alu_result_o(alu_result_q),
    .rd_data_o(rd_data_q), .pc_plus4_o(pc_plus4_q), .instruction_o(instruction_q),
    .rd_addr_o(rd_addr_q), .RegWrite_o(reg_write_q), .WBSel_o(wb_sel_q),
    .misaligned_o(misaligned_q)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> (8 * addr[1:0]);
    case (f3)
      3'b000:  return 32'($signed(sh[7:0]));
      3'b100:  return sh & 32'hFF;
      3'b001:  return 32'($signed(sh[15:0]));
      3'b101:  return sh & 32'hFFFF;
      default: return word;
    endcase
  endfunction

  task automatic go_idle();
    ex_valid  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(posedge clk); #1;
    chk("idle_wb_valid", wb_valid, 0);
    chk("idle_regwrite", reg_write_q, 0);
  endtask

  // kind: 0 = ALU op, 1 = load, 2 = store; gd = cycles before gnt, rd = cycles before rvalid
  task automatic run_op(input int kind, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] rs2, input int gd, input int rd,
                        input logic [31:0] word, input logic rw, input logic [1:0] wbs);
    int          nb;
    logic        mis;
    logic [31:0] exp_rd, exp_wd;
    logic [3:0]  exp_be;
    ex_valid    = 1'b1;
    alu_result  = addr;
    rs2_data    = rs2;
    pc_plus4    = $urandom;
    instruction = $urandom;
    rd_addr     = 5'($urandom);
    reg_write   = rw;
    mem_read    = (kind == 1);
    mem_write   = (kind == 2);
    funct3      = f3;
    wb_sel      = wbs;
    nb          = 1 << f3[1:0];
    mis         = (kind != 0) && ((addr % nb) != 0);
    exp_rd      = 32'd0;
    if (kind == 0 || mis) begin
      @(negedge clk);
      chk("nomem_req", dmem_req, 0);
      chk("nomem_stall", mem_stall, 0);
      @(posedge clk); #1;
    end else begin
      for (int i = 0; i < gd; i++) begin
        @(negedge clk);
        chk("wait_gnt_req", dmem_req, 1);
        chk("wait_gnt_stall", mem_stall, 1);
        @(posedge clk); #1;
        chk("wait_gnt_bubble", wb_valid, 0);
      end
      exp_be = (nb == 4) ? 4'hF : 4'(((nb == 1) ? 1 : 3) << addr[1:0]);
      exp_wd = (nb == 1) ? rs2[7:0] * 32'h01010101 :
               (nb == 2) ? rs2[15:0] * 32'h00010001 : rs2;
      dmem_gnt = 1'b1;
      @(negedge clk);
      chk("gnt_req", dmem_req, 1);
      chk("gnt_we", dmem_we, (kind == 2));
      chk("gnt_addr", dmem_addr, addr & 32'hFFFF_FFFC);
      chk("gnt_stall", mem_stall, (kind == 1));
      if (kind == 2) begin
        chk("st_be", dmem_be, exp_be);
        chk("st_wdata", dmem_wdata, exp_wd);
      end else begin
        chk("ld_be", dmem_be, 4'hF);
      end
      @(posedge clk); #1;
      dmem_gnt = 1'b0;
      if (kind == 1) begin
        chk("ld_gnt_bubble", wb_valid, 0);
        for (int i = 0; i < rd; i++) begin
          @(negedge clk);
          chk("wait_rd_req", dmem_req, 0);
          chk("wait_rd_stall", mem_stall, 1);
          @(posedge clk); #1;
        end
        dmem_rvalid = 1'b1;
        dmem_rdata  = word;
        @(negedge clk);
        chk("rvalid_stall", mem_stall, 0);
        chk("rvalid_req", dmem_req, 0);
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        dmem_rdata  = $urandom;
        exp_rd      = model_load(f3, addr, word);
      end
    end
    chk("wb_valid", wb_valid, 1);
    chk("wb_alu_result", alu_result_q, addr);
    chk("wb_pc_plus4", pc_plus4_q, pc_plus4);
    chk("wb_instruction", instruction_q, instruction);
    chk("wb_rd_addr", rd_addr_q, rd_addr);
    chk("wb_regwrite", reg_write_q, rw & ~mis);
    chk("wb_wbsel", wb_sel_q, wbs);
    chk("wb_misaligned", misaligned_q, mis);
    chk("wb_rd_data", rd_data_q, exp_rd);
  endtask

  initial begin
    logic [2:0] ld_f3 [5];
    int         kind;
    logic [2:0] f3;
    ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    rst_n = 1'b0; ex_valid = 1'b0; alu_result = '0; rs2_data = '0; pc_plus4 = '0;
    instruction = '0; rd_addr = '0; reg_write = 1'b0; mem_read = 1'b0;
    mem_write = 1'b0; funct3 = '0; wb_sel = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_alu_result", alu_result_q, 0);
    chk("rst_rd_data", rd_data_q, 0);
    chk("rst_regwrite", reg_write_q, 0);
    chk("rst_misaligned", misaligned_q, 0);
    rst_n = 1'b1;

    run_op(0, 3'b000, 32'h10, 32'h0, 0, 0, 32'h0, 1'b1, 2'd0);          // ADD
    run_op(2, 3'b000, 32'h1003, 32'hAB, 0, 0, 32'h0, 1'b0, 2'd0);      // SB
    chk("sb_be_fixed", dmem_be, 4'b1000);
    run_op(1, 3'b000, 32'h2001, 32'h0, 2, 1, 32'h0000_8000, 1'b1, 2'd1); // LB
    run_op(1, 3'b100, 32'h2001, 32'h0, 2, 0, 32'h0000_8000, 1'b1, 2'd1); // LBU
    run_op(1, 3'b010, 32'h2002, 32'h0, 0, 0, 32'h0, 1'b1, 2'd1);        // LW misaligned
    go_idle();

    // Reset while a load waits for data; the late rvalid must be ignored.
    ex_valid = 1'b1; alu_result = 32'h3000; mem_read = 1'b1; mem_write = 1'b0;
    funct3 = 3'b010; reg_write = 1'b1; dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    rst_n = 1'b0; ex_valid = 1'b0; mem_read = 1'b0;
    @(posedge clk); #1;
    chk("rst2_wb_valid", wb_valid, 0);
    chk("rst2_alu_result", alu_result_q, 0);
    chk("rst2_regwrite", reg_write_q, 0);
    rst_n = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("late_rvalid_stall", mem_stall, 0);
    chk("late_rvalid_req", dmem_req, 0);
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    chk("late_rvalid_wb", wb_valid, 0);

    // Back-to-back SW then LW with zero-wait memory.
    run_op(2, 3'b010, 32'h4000, 32'h1234_5678, 0, 0, 32'h0, 1'b0, 2'd0);
    run_op(1, 3'b010, 32'h4004, 32'h0, 0, 0, 32'hCAFE_F00D, 1'b1, 2'd1);
    run_op(1, 3'b001, 32'h4006, 32'h0, 1, 2, 32'h9ABC_1234, 1'b1, 2'd1);
    run_op(1, 3'b101, 32'h4006, 32'h0, 0, 1, 32'h9ABC_1234, 1'b1, 2'd1);
    run_op(2, 3'b001, 32'h5001, 32'h0, 0, 0, 32'h0, 1'b0, 2'd0);        // SH misaligned

    for (int n = 0; n < 60; n++) begin
      kind = int'($urandom_range(0, 2));
      f3   = (kind == 1) ? ld_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
      run_op(kind, f3, $urandom, $urandom, int'($urandom_range(0, 3)),
             int'($urandom_range(0, 2)), $urandom, 1'($urandom),
             (kind == 1) ? 2'd1 : 2'($urandom_range(0, 2)));
      if ($urandom_range(0, 3) == 0) go_idle();
    end
    go_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
